// File: rtl/cpu_arb_pkg.sv
// Shared arbiter types: default sizes, FSM state and one-hot decode.
package cpu_arb_pkg;

  localparam int unsigned N_DEF = 4;
  localparam int unsigned W_DEF = 32;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // OR-reduction decode; only meaningful for one-hot or zero input (up to 8 lines).
  function automatic logic [2:0] onehot_to_index(input logic [7:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) idx = idx | 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_onehot_arbiter_if.sv
// Request/select/downstream bundle between requesters, arbiter and consumer.
interface rr_onehot_arbiter_if #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 32
);
  logic [N-1:0]   req;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   grant;
  logic [N-1:0]   sel_onehot;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic           out_ready;

  modport master (
    input  req, req_data, out_ready,
    output grant, sel_onehot, out_valid, out_data
  );

  modport slave (
    output req, req_data, out_ready,
    input  grant, sel_onehot, out_valid, out_data
  );
endinterface

// File: rtl/rr_onehot_pick.sv
// Rotating-priority picker: first asserted req scanning from ptr upward with wrap.
module rr_onehot_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  pick
);

  logic          found;
  logic [PW-1:0] idx;

  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = PW'((32'(ptr) + 32'(k)) % N);
      if (!found && req[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_onehot_arbiter.sv
// Registered round-robin arbiter producing a one-hot select and a captured word on valid/ready.
module rr_onehot_arbiter
  import cpu_arb_pkg::*;
#(
  parameter int unsigned N = N_DEF,
  parameter int unsigned W = W_DEF
) (
  input logic                 clk,
  input logic                 resetn,
  rr_onehot_arbiter_if.master bus
);

  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

  state_t        state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [N-1:0]  sel_q, sel_d;
  logic          valid_q, valid_d;
  logic [W-1:0]  data_q, data_d;
  logic [N-1:0]  pick_c;
  logic [W-1:0]  mux_c;
  logic [2:0]    win_idx_c;
  logic          free_c;

  rr_onehot_pick #(.N(N), .PW(PW)) u_pick (
    .req  (bus.req),
    .ptr  (ptr_q),
    .pick (pick_c)
  );

  // One-hot AND-OR word select, same structure as the datapath muxes.
  always_comb begin
    mux_c = '0;
    for (int unsigned i = 0; i < N; i++) begin
      mux_c = mux_c | (bus.req_data[i*W +: W] & {W{pick_c[i]}});
    end
  end

  assign win_idx_c = onehot_to_index(8'(pick_c));
  assign free_c    = (state_q == IDLE) || (valid_q && bus.out_ready);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (free_c) state_d = (|pick_c) ? BUSY : IDLE;
  end

  // Next register values; a stalled slot holds everything and suppresses grant.
  always_comb begin
    grant_d = '0;
    sel_d   = sel_q;
    valid_d = valid_q;
    data_d  = data_q;
    ptr_d   = ptr_q;
    if (free_c) begin
      grant_d = pick_c;
      sel_d   = pick_c;
      valid_d = |pick_c;
      if (|pick_c) begin
        data_d = mux_c;
        ptr_d  = (32'(win_idx_c) == N - 1) ? '0 : PW'(32'(win_idx_c) + 32'd1);
      end
    end
  end

  assign bus.grant      = grant_q;
  assign bus.sel_onehot = sel_q;
  assign bus.out_valid  = valid_q;
  assign bus.out_data   = data_q;

endmodule

// File: doc/rr_onehot_arbiter.md
Name: rr_onehot_arbiter

Overview:
- Registered round-robin arbiter. Turns N raw request lines into a registered one-hot select, which drives the team's one-hot MUXn_32b datapath muxes.
- Sits in front of a shared resource (memory port, writeback bus). Captures the winning requester's data word and presents it downstream on a valid/ready handshake.
- It is the producer side of the one-hot select interface: it generates the oneHot vector that the muxes consume. It guarantees at most one bit is set and rotates priority fairly.

Parameters:
- N, 4, number of requesters (2..8).
- W, 32, data word width.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- req  in  N  request per requester; held high by the requester until its grant pulse.
- req_data  in  N*W  packed words; requester i occupies bits [i*W+W-1 : i*W].
- grant  out  N  one-hot, one-cycle acknowledge pulse to the winner; the winner may drop or change req next cycle.
- sel_onehot  out  N  registered one-hot select of the currently presented requester; all-zero when nothing is held.
- out_valid  out  1  out_data holds an accepted word.
- out_data  out  W  captured word of the winner.
- out_ready  in  1  downstream accepts when out_valid && out_ready.

Behaviour:
- Reset (resetn low, asynchronous, effective immediately, including mid-transfer):
  - grant = 0, sel_onehot = 0, out_valid = 0, out_data = 0, priority pointer ptr = 0, state = IDLE.
  - A word held at reset is discarded.
- Pick function (combinational): first asserted req bit scanning ptr, ptr+1, ..., N-1, 0, ..., ptr-1. The result is one-hot or zero.
- free = (state == IDLE) || (out_valid && out_ready).
- On each edge where free:
  - If pick != 0:
    - grant <= pick for exactly one cycle.
    - sel_onehot <= pick.
    - out_data <= the selected word, built as a one-hot AND-OR across req_data.
    - out_valid <= 1, state <= BUSY.
    - ptr <= (index(pick) + 1) mod N; wraps N-1 -> 0.
  - If pick == 0:
    - grant <= 0, out_valid <= 0, sel_onehot <= 0, state <= IDLE.
    - ptr unchanged.
- On each edge where not free (BUSY and stalled):
  - grant <= 0.
  - out_valid, out_data, sel_onehot and ptr all hold.
  - Incoming requests wait.
- Latency: req sampled high at edge t gives grant, out_valid and out_data visible after edge t+1 (one cycle).
- Throughput: back-to-back with out_ready held high; one word per cycle.
- States:
  - IDLE -> BUSY on pick != 0.
  - BUSY -> BUSY on handshake with a new pick, or on stall.
  - BUSY -> IDLE on handshake with no request.
- Invariants:
  - $onehot0(grant) and $onehot0(sel_onehot) hold at all times.
  - grant is never asserted on a cycle where the previous word is still stalled.
  - out_data is stable while out_valid && !out_ready.
- Boundary cases:
  - A requester withdrawing req before being granted is legal; it is simply skipped.
  - A request arriving in the same cycle as a handshake competes in that cycle's pick.
  - The same requester can win consecutive slots only if no other request is asserted.
  - out_ready while out_valid == 0 is ignored.

Decomposition:
- Shared package (cpu_arb_pkg):
  - default N/W constants.
  - state enum {IDLE, BUSY}.
  - onehot-to-index function, reused by the datapath decode.
- One sub-module, rr_onehot_pick:
  - combinational rotate-priority picker.
  - inputs req[N] and ptr[$clog2(N)]; output pick[N].
  - Verified stand-alone with exhaustive req/ptr sweep.
- The data capture reuses the AND-OR one-hot mux style; no separate module.

Test Plan:
- Reset then idle: resetn=0 for 2 cycles, req=0 -> grant=0, sel_onehot=0, out_valid=0, out_data=0 for 10 cycles.
- Single request: req=4'b0100, word2=32'hDEAD_BEEF, out_ready=1 -> next cycle grant=4'b0100, sel_onehot=4'b0100, out_data=32'hDEADBEEF, out_valid=1; req dropped -> out_valid=0 the cycle after.
- Fairness/wrap: req=4'b1111 held, out_ready=1 -> grants in order 0001, 0010, 0100, 1000, 0001; ptr wraps 3->0.
- Backpressure: winner 1 with data 32'h1111_1111, out_ready=0 for 3 cycles while req=4'b1010 -> out_data holds 32'h11111111, grant=0 throughout; on out_ready=1, next grant=4'b1000.
- Withdrawal: req=4'b0011 with ptr=1; requester 1 drops req the cycle before the edge -> grant=4'b0001, ptr=1.
- Reset mid-stall: out_valid=1, out_ready=0, resetn pulsed low asynchronously between edges -> out_valid=0 immediately; after release with req=4'b1000 the first grant is 4'b1000 (ptr restarted at 0).
